// File: rtl/axist_pat_chkr.sv
// AXI-Stream receive pattern checker: compares each accepted beat against a locally
// generated incrementing / alternating / LFSR / walking-one word and reports the result.
module axist_pat_chkr #(
    parameter int DWIDTH = 256,
    parameter int ERR_W  = 16
) (
    input  logic              wr_clk,
    input  logic              rst_n,
    input  logic              chkr_en,
    input  logic [1:0]        patgen_sel,
    input  logic [8:0]        patgen_cnt,
    input  logic              cntuspatt_en,
    input  logic              axist_tvalid,
    input  logic [DWIDTH-1:0] axist_tdata,
    output logic              axist_tready,
    output logic [1:0]        chkr_pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [8:0]        first_err_beat,
    output logic [8:0]        beat_cnt,
    output logic              chkr_busy,
    output logic [1:0]        fsm_state
);

    localparam int          LANES     = DWIDTH / 32;
    localparam int          WPW       = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Handshake: a beat transfers on a rising wr_clk edge where axist_tvalid and
    // axist_tready are both 1; tready is registered and is 1 only while in CHECK.

    state_t           state;
    logic             en_q;
    logic [1:0]       sel_q;
    logic [8:0]       cnt_q;
    logic             cont_q;
    logic [31:0]      inc_base;
    logic             alt_odd;
    logic [31:0]      lfsr_q;
    logic [WPW-1:0]   walk_pos;

    logic [DWIDTH-1:0] exp_word;
    logic [31:0]       lane_lfsr;
    logic [31:0]       lfsr_next;
    logic              accept;
    logic              mismatch;
    logic [ERR_W-1:0]  err_nxt;
    logic [8:0]        beat_nxt;

    // Right-shifting Galois step: feedback from bit 0 XORs the tap mask.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    always_comb begin
        exp_word  = '0;
        lane_lfsr = lfsr_q;
        for (int i = 0; i < LANES; i++) begin
            case (sel_q)
                2'b00:   exp_word[32*i +: 32] = inc_base + 32'(i);
                2'b01:   exp_word[32*i +: 32] = alt_odd ? 32'h5555_5555 : 32'hAAAA_AAAA;
                2'b10:   exp_word[32*i +: 32] = lane_lfsr;
                default: ;
            endcase
            lane_lfsr = lfsr_step(lane_lfsr);
        end
        lfsr_next = lane_lfsr;
        if (sel_q == 2'b11) exp_word[walk_pos] = 1'b1;
    end

    assign accept   = axist_tvalid & axist_tready;
    assign mismatch = accept && (axist_tdata != exp_word);
    assign beat_nxt = beat_cnt + 9'd1;
    assign err_nxt  = (mismatch && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;
    assign fsm_state = state;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            en_q           <= 1'b0;
            sel_q          <= 2'b00;
            cnt_q          <= 9'd0;
            cont_q         <= 1'b0;
            inc_base       <= 32'd0;
            alt_odd        <= 1'b0;
            lfsr_q         <= LFSR_SEED;
            walk_pos       <= '0;
            axist_tready   <= 1'b0;
            chkr_pass      <= 2'b00;
            err_cnt        <= '0;
            first_err_beat <= 9'd0;
            beat_cnt       <= 9'd0;
            chkr_busy      <= 1'b0;
        end else begin
            en_q <= chkr_en;
            if (accept) begin
                err_cnt  <= err_nxt;
                // err_cnt saturates and never returns to zero, so zero means no prior error
                if (mismatch && (err_cnt == '0)) first_err_beat <= beat_cnt;
                beat_cnt <= beat_nxt;
                inc_base <= inc_base + 32'(LANES);
                alt_odd  <= ~alt_odd;
                lfsr_q   <= lfsr_next;
                walk_pos <= (walk_pos == WPW'(DWIDTH - 1)) ? '0 : walk_pos + WPW'(1);
            end
            case (state)
                IDLE: begin
                    if (chkr_en && !en_q) begin
                        state     <= ARM;
                        chkr_busy <= 1'b1;
                    end
                end
                ARM: begin
                    sel_q          <= patgen_sel;
                    cnt_q          <= patgen_cnt;
                    cont_q         <= cntuspatt_en;
                    err_cnt        <= '0;
                    beat_cnt       <= 9'd0;
                    first_err_beat <= 9'd0;
                    inc_base       <= 32'd0;
                    alt_odd        <= 1'b0;
                    lfsr_q         <= LFSR_SEED;
                    walk_pos       <= '0;
                    if (!chkr_en) begin
                        state     <= IDLE;
                        chkr_busy <= 1'b0;
                    end else if (!cntuspatt_en && (patgen_cnt == 9'd0)) begin
                        state     <= DONE;
                        chkr_busy <= 1'b0;
                        chkr_pass <= 2'b11;
                    end else begin
                        state        <= CHECK;
                        axist_tready <= 1'b1;
                    end
                end
                CHECK: begin
                    if (!chkr_en) begin
                        axist_tready <= 1'b0;
                        chkr_busy    <= 1'b0;
                        // continuous runs end by dropping enable, so they still report
                        if (cont_q) begin
                            state     <= DONE;
                            chkr_pass <= {1'b1, err_nxt == '0};
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!cont_q && accept && (beat_nxt == cnt_q)) begin
                        state        <= DONE;
                        axist_tready <= 1'b0;
                        chkr_busy    <= 1'b0;
                        chkr_pass    <= {1'b1, err_nxt == '0};
                    end
                end
                DONE: begin
                    if (!chkr_en) begin
                        state     <= IDLE;
                        chkr_pass <= 2'b00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axist_pat_chkr.sv
// Directed bench for axist_pat_chkr: a driver feeds beats, a monitor scores each run's
// end-of-run status (taken when chkr_busy falls) against an expected queue.
module tb_axist_pat_chkr;

    localparam int DW    = 256;
    localparam int LANES = DW / 32;
    localparam int RW    = 36;

    logic          wr_clk = 1'b0;
    logic          rst_n;
    logic          chkr_en;
    logic [1:0]    patgen_sel;
    logic [8:0]    patgen_cnt;
    logic          cntuspatt_en;
    logic          axist_tvalid;
    logic [DW-1:0] axist_tdata;

    logic          axist_tready;
    logic [1:0]    chkr_pass;
    logic [15:0]   err_cnt;
    logic [8:0]    first_err_beat;
    logic [8:0]    beat_cnt;
    logic          chkr_busy;
    logic [1:0]    fsm_state;

    logic          s_tready;
    logic [1:0]    s_chkr_pass;
    logic [3:0]    s_err_cnt;
    logic [8:0]    s_first_err_beat;
    logic [8:0]    s_beat_cnt;
    logic          s_chkr_busy;
    logic [1:0]    s_fsm_state;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [RW-1:0] exp_q[$];
    logic          mon_busy_prev = 1'b0;

    always #5 wr_clk = ~wr_clk;

    axist_pat_chkr #(.DWIDTH(DW), .ERR_W(16)) dut (
        .wr_clk(wr_clk), .rst_n(rst_n), .chkr_en(chkr_en), .patgen_sel(patgen_sel),
        .patgen_cnt(patgen_cnt), .cntuspatt_en(cntuspatt_en), .axist_tvalid(axist_tvalid),
        .axist_tdata(axist_tdata), .axist_tready(axist_tready), .chkr_pass(chkr_pass),
        .err_cnt(err_cnt), .first_err_beat(first_err_beat), .beat_cnt(beat_cnt),
        .chkr_busy(chkr_busy), .fsm_state(fsm_state)
    );

    axist_pat_chkr #(.DWIDTH(DW), .ERR_W(4)) dut_s (
        .wr_clk(wr_clk), .rst_n(rst_n), .chkr_en(chkr_en), .patgen_sel(patgen_sel),
        .patgen_cnt(patgen_cnt), .cntuspatt_en(cntuspatt_en), .axist_tvalid(axist_tvalid),
        .axist_tdata(axist_tdata), .axist_tready(s_tready), .chkr_pass(s_chkr_pass),
        .err_cnt(s_err_cnt), .first_err_beat(s_first_err_beat), .beat_cnt(s_beat_cnt),
        .chkr_busy(s_chkr_busy), .fsm_state(s_fsm_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] pack(input logic [1:0] pass, input int err,
                                           input int first, input int beat);
        return {pass, 16'(err), 9'(first), 9'(beat)};
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // Reference word for beat n, derived from scratch rather than incrementally.
    function automatic logic [DW-1:0] exp_word(input logic [1:0] sel, input int n);
        logic [DW-1:0] w;
        logic [31:0]   s;
        w = '0;
        case (sel)
            2'b00: for (int i = 0; i < LANES; i++) w[32*i +: 32] = 32'(n * LANES + i);
            2'b01: for (int i = 0; i < LANES; i++)
                       w[32*i +: 32] = (n % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
            2'b10: begin
                s = 32'hFFFF_FFFF;
                repeat (n * LANES) s = lfsr_step(s);
                for (int i = 0; i < LANES; i++) begin
                    w[32*i +: 32] = s;
                    s = lfsr_step(s);
                end
            end
            default: w[n % DW] = 1'b1;
        endcase
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] sel, input int cnt, input logic cont);
        patgen_sel   = sel;
        patgen_cnt   = 9'(cnt);
        cntuspatt_en = cont;
        chkr_en      = 1'b1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input int gap);
        int t;
        axist_tvalid = 1'b0;
        axist_tdata  = ~d;
        repeat (gap) tick(1);
        axist_tvalid = 1'b1;
        axist_tdata  = d;
        t = 0;
        do begin
            @(negedge wr_clk);
            t++;
        end while (!axist_tready && t < 100);
        check("beat_accept", axist_tready, 1);
        tick(1);
        axist_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge wr_clk);
        while (!chkr_pass[1] && t < 100) begin
            @(negedge wr_clk);
            t++;
        end
        check("done_seen", chkr_pass[1], 1);
        tick(1);
    endtask

    task automatic release_en();
        chkr_en = 1'b0;
        tick(3);
    endtask

    // Monitor: every end of a run (busy falling) yields one status record.
    initial begin
        logic [RW-1:0] got;
        logic [RW-1:0] e;
        forever begin
            @(negedge wr_clk);
            if (mon_busy_prev && !chkr_busy) begin
                got = {chkr_pass, err_cnt, first_err_beat, beat_cnt};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL result_unexpected: got pass=%b err=%0d first=%0d beat=%0d",
                             got[35:34], got[33:18], got[17:9], got[8:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_bad++;
                        $display("FAIL result: got pass=%b err=%0d first=%0d beat=%0d expected pass=%b err=%0d first=%0d beat=%0d",
                                 got[35:34], got[33:18], got[17:9], got[8:0],
                                 e[35:34], e[33:18], e[17:9], e[8:0]);
                    end
                end
            end
            mon_busy_prev = chkr_busy;
        end
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: run did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [DW-1:0] d;
        rst_n        = 1'b1;
        chkr_en      = 1'b0;
        patgen_sel   = 2'b00;
        patgen_cnt   = 9'd0;
        cntuspatt_en = 1'b0;
        axist_tvalid = 1'b0;
        axist_tdata  = '0;
        #2 rst_n = 1'b0;
        tick(3);
        @(negedge wr_clk);
        check("rst_tready", axist_tready, 0);
        check("rst_pass", chkr_pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_first", first_err_beat, 0);
        check("rst_beat", beat_cnt, 0);
        check("rst_busy", chkr_busy, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Incrementing, 4 back-to-back good beats
        exp_q.push_back(pack(2'b11, 0, 0, 4));
        arm(2'b00, 4, 1'b0);
        for (int n = 0; n < 4; n++) send_beat(exp_word(2'b00, n), 0);
        check("tready_after_last", axist_tready, 0);
        wait_done();
        tick(2);
        check("done_hold", chkr_pass, 2'b11);
        release_en();

        // LFSR, beat 1 bit 5 flipped, idle gaps carrying garbage data
        exp_q.push_back(pack(2'b10, 1, 1, 3));
        arm(2'b10, 3, 1'b0);
        send_beat(exp_word(2'b10, 0), 0);
        d = exp_word(2'b10, 1);
        d[5] = ~d[5];
        send_beat(d, 2);
        send_beat(exp_word(2'b10, 2), 3);
        wait_done();
        release_en();

        // Alternating, continuous, 600 beats; select/count changed mid-run
        exp_q.push_back(pack(2'b11, 0, 0, 88));
        arm(2'b01, 5, 1'b1);
        send_beat(exp_word(2'b01, 0), 0);
        patgen_sel   = 2'b00;
        patgen_cnt   = 9'd1;
        cntuspatt_en = 1'b0;
        for (int n = 1; n < 600; n++) send_beat(exp_word(2'b01, n), 0);
        chkr_en = 1'b0;
        tick(3);
        check("cont_back_idle", chkr_pass, 2'b00);
        tick(1);

        // Zero-length run
        exp_q.push_back(pack(2'b11, 0, 0, 0));
        arm(2'b00, 0, 1'b0);
        @(posedge wr_clk);
        @(negedge wr_clk);
        check("cnt0_arm_busy", chkr_busy, 1);
        check("cnt0_arm_tready", axist_tready, 0);
        check("cnt0_arm_pass", chkr_pass, 2'b00);
        @(negedge wr_clk);
        check("cnt0_pass", chkr_pass, 2'b11);
        check("cnt0_tready", axist_tready, 0);
        tick(1);
        release_en();

        // Walking-one, abort after 3rd beat (accepted in the abort cycle)
        exp_q.push_back(pack(2'b00, 1, 1, 3));
        arm(2'b11, 5, 1'b0);
        send_beat(exp_word(2'b11, 0), 0);
        d = exp_word(2'b11, 1);
        d[0] = ~d[0];
        send_beat(d, 0);
        chkr_en = 1'b0;
        send_beat(exp_word(2'b11, 2), 0);
        tick(2);
        check("abort_pass", chkr_pass, 2'b00);
        check("abort_err_kept", err_cnt, 1);
        tick(1);

        // Every beat wrong: 16-bit counter reaches 20, 4-bit counter saturates
        exp_q.push_back(pack(2'b10, 20, 0, 20));
        arm(2'b00, 20, 1'b0);
        for (int n = 0; n < 20; n++) send_beat(~exp_word(2'b00, n), 0);
        wait_done();
        check("sat_err", s_err_cnt, 15);
        check("sat_first", s_first_err_beat, 0);
        check("sat_pass", s_chkr_pass, 2'b10);
        release_en();

        // Reset in the middle of a run discards it
        exp_q.push_back(pack(2'b00, 0, 0, 0));
        arm(2'b00, 10, 1'b0);
        send_beat(exp_word(2'b00, 0), 0);
        send_beat(exp_word(2'b00, 1), 0);
        rst_n = 1'b0;
        tick(2);
        check("rstmid_err", err_cnt, 0);
        check("rstmid_beat", beat_cnt, 0);
        check("rstmid_tready", axist_tready, 0);
        chkr_en = 1'b0;
        rst_n   = 1'b1;
        tick(2);

        // Enable held high through reset release arms immediately
        rst_n = 1'b0;
        arm(2'b00, 0, 1'b0);
        exp_q.push_back(pack(2'b11, 0, 0, 0));
        tick(2);
        rst_n = 1'b1;
        @(posedge wr_clk);
        @(negedge wr_clk);
        check("arm_after_rst", chkr_busy, 1);
        wait_done();
        release_en();

        tick(2);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
